uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_tick.sv | 35 +++
 rtl/uart_rx.sv | 179 +++++++++++++++++
 tb/tb_uart_rx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver state type and default baud/bit constants.
// Optional feature macro: UART_RX_PARITY_EN (adds the parity state).
package uart_pkg;

  localparam int BAUD_CW_DEF  = 9;
  localparam int FULL_TOP_DEF = 434;
  localparam int HALF_TOP_DEF = 217;
  localparam int BIT_CW_DEF   = 4;
  localparam int DATA_BITS    = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_RX_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_tick.sv
// uart_rx_tick: baud counter with half-bit and full-bit ticks.
// Counts 0..FULL-1 and wraps; clr restarts the count at 0.
module uart_rx_tick #(
  parameter int BAUD_COUNT_WIDTH    = 9,
  parameter int FULL_BAUD_COUNT_TOP = 434,
  parameter int HALF_BAUD_COUNT_TOP = 217
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic half_tick,
  output logic full_tick
);

  localparam logic [BAUD_COUNT_WIDTH-1:0] FULL_M1 =
    BAUD_COUNT_WIDTH'(FULL_BAUD_COUNT_TOP - 1);
  localparam logic [BAUD_COUNT_WIDTH-1:0] HALF_M1 =
    BAUD_COUNT_WIDTH'(HALF_BAUD_COUNT_TOP - 1);

  logic [BAUD_COUNT_WIDTH-1:0] cnt;

  assign full_tick = (cnt == FULL_M1);
  assign half_tick = (cnt == HALF_M1);

  // free-running baud count, restarted on clear or wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr || full_tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver with valid/ready output and error pulses.
// Optional feature macro: UART_RX_PARITY_EN (even parity, parity_err port).
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_COUNT_WIDTH    = BAUD_CW_DEF,
  parameter int FULL_BAUD_COUNT_TOP = FULL_TOP_DEF,
  parameter int HALF_BAUD_COUNT_TOP = HALF_TOP_DEF,
  parameter int BIT_COUNT_WIDTH     = BIT_CW_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_dat_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       overrun
);

  localparam logic [BIT_COUNT_WIDTH-1:0] LAST_BIT =
    BIT_COUNT_WIDTH'(DATA_BITS - 1);

  logic s1, line, line_q, fall;
  rx_state_t state, state_n;
  logic clr, half_tick, full_tick;
  logic take_bit, good, bad_stop;
  logic brk;
  logic [BIT_COUNT_WIDTH-1:0] bit_cnt;
  logic [7:0] shreg;
`ifdef UART_RX_PARITY_EN
  logic par_take, par_bad;
`endif

  assign fall = line_q & ~line;

  // two-flop synchronizer plus one delayed copy for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= 1'b1;
      line   <= 1'b1;
      line_q <= 1'b1;
    end else begin
      s1     <= serial_dat_in;
      line   <= s1;
      line_q <= line;
    end
  end

  uart_rx_tick #(
    .BAUD_COUNT_WIDTH   (BAUD_COUNT_WIDTH),
    .FULL_BAUD_COUNT_TOP(FULL_BAUD_COUNT_TOP),
    .HALF_BAUD_COUNT_TOP(HALF_BAUD_COUNT_TOP)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .half_tick(half_tick),
    .full_tick(full_tick)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= RX_IDLE;
    else
      state <= state_n;
  end

  // next state and per-cycle strobes
  always_comb begin
    state_n  = state;
    take_bit = 1'b0;
    good     = 1'b0;
    bad_stop = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_take = 1'b0;
`endif
    unique case (state)
      RX_IDLE:
        if (fall) state_n = RX_START;
      RX_START:
        if (half_tick)
          state_n = line ? RX_IDLE : RX_DATA;
      RX_DATA:
        if (full_tick) begin
          take_bit = 1'b1;
          if (bit_cnt == LAST_BIT)
`ifdef UART_RX_PARITY_EN
            state_n = RX_PARITY;
`else
            state_n = RX_STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
      RX_PARITY:
        if (full_tick) begin
          par_take = 1'b1;
          state_n  = RX_STOP;
        end
`endif
      RX_STOP:
        if (brk) begin
          if (line) state_n = RX_IDLE;
        end else if (full_tick) begin
          if (line) begin
`ifdef UART_RX_PARITY_EN
            good = ~par_bad;
`else
            good = 1'b1;
`endif
            state_n = RX_IDLE;
          end else begin
            bad_stop = 1'b1;
          end
        end
      default:
        state_n = RX_IDLE;
    endcase
    clr = (state_n != state);
  end

  // bit counter, shift register and break tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
      brk     <= 1'b0;
    end else begin
      if (state == RX_START)
        bit_cnt <= '0;
      else if (take_bit)
        bit_cnt <= bit_cnt + 1'b1;
      if (take_bit)
        shreg <= {line, shreg[7:1]};
      if (bad_stop)
        brk <= 1'b1;
      else if (state_n == RX_IDLE)
        brk <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  // even parity: data ones plus parity bit must be even
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= par_take && (line != ^shreg);
      if (par_take)
        par_bad <= (line != ^shreg);
    end
  end
`endif

  // output byte, handshake and error pulses; consume wins over hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      overrun   <= good && rx_valid && !rx_ready;
      if (good && !(rx_valid && !rx_ready)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at default baud settings.
// Directed frames, a vector table and randomized frames vs a byte model.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int BIT = 434;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int STOP_MID = (NBITS - 1) * BIT + BIT / 2;

  logic clk = 1'b0;
  logic rst, serial_dat_in, rx_ready;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
  bit par_flip = 1'b0;
  int perr_cnt = 0;
`endif

  uart_rx dut (
    .clk          (clk),
    .rst          (rst),
    .serial_dat_in(serial_dat_in),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .frame_err    (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err   (parity_err),
`endif
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ferr_cnt = 0, ovr_cnt = 0;
  int vrise_cnt = 0, vrise_cyc = 0;
  int t_start = 0;
  logic v_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) perr_cnt++;
`endif
    if (rx_valid === 1'b1 && !v_q) begin
      vrise_cnt++;
      vrise_cyc = cyc;
    end
    v_q = (rx_valid === 1'b1);
  end

  initial begin
    repeat (98000) @(posedge clk);
    $display("FAIL watchdog: cycle budget %0d exhausted, required finish", cyc);
    $fatal(1);
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input bit stop_ok,
                            input int low_hold);
    t_start = cyc;
    serial_dat_in = 1'b0;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      serial_dat_in = d[i];
      idle(BIT);
    end
`ifdef UART_RX_PARITY_EN
    serial_dat_in = (^d) ^ par_flip;
    idle(BIT);
`endif
    if (stop_ok) begin
      serial_dat_in = 1'b1;
      idle(BIT);
    end else begin
      serial_dat_in = 1'b0;
      idle(low_hold);
      serial_dat_in = 1'b1;
    end
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] d;
    bit         stop_ok;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_ferr;
  } vec_t;

  vec_t tbl[3];
  int f0, o0, v0, lat;
  logic [7:0] rd;
  bit ok;
  logic m_valid;
  logic [7:0] m_data;
  int e_ferr, e_ovr;

  initial begin
    tbl[0] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
    tbl[1] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
    tbl[2] = '{8'h81, 1'b0, 1'b0, 8'hFF, 1};

    rst = 1'b1;
    serial_dat_in = 1'b1;
    rx_ready = 1'b0;
    idle(3);
    check("reset_data", rx_data, 8'h00);
    check("reset_valid", rx_valid, 0);
    check("reset_ferr", frame_err, 0);
    check("reset_ovr", overrun, 0);
    rst = 1'b0;
    idle(5);

    f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1, 0);
    idle(10);
    check("a5_data", rx_data, 8'hA5);
    check("a5_valid", rx_valid, 1);
    check("a5_ferr", ferr_cnt - f0, 0);
    lat = vrise_cyc - t_start;
    check("a5_latency", lat >= STOP_MID && lat <= STOP_MID + 8, 1);
    consume();
    check("a5_consumed", rx_valid, 0);

    v0 = vrise_cnt;
    f0 = ferr_cnt;
    serial_dat_in = 1'b0;
    idle(100);
    serial_dat_in = 1'b1;
    idle(200);
    check("glitch_no_valid", vrise_cnt - v0, 0);
    check("glitch_no_ferr", ferr_cnt - f0, 0);

    send_frame(8'h3C, 1'b0, 2000);
    idle(10);
    check("break_ferr_once", ferr_cnt - f0, 1);
    check("break_no_valid", vrise_cnt - v0, 0);
    send_frame(8'h55, 1'b1, 0);
    idle(10);
    check("after_break_data", rx_data, 8'h55);
    check("after_break_valid", rx_valid, 1);
    check("after_break_ferr", ferr_cnt - f0, 1);
    consume();

    o0 = ovr_cnt;
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    idle(10);
    check("ovr_data_kept", rx_data, 8'h11);
    check("ovr_valid", rx_valid, 1);
    check("ovr_pulse", ovr_cnt - o0, 1);
    consume();
    check("ovr_consumed", rx_valid, 0);

    v0 = vrise_cnt;
    fork
      send_frame(8'hF0, 1'b1, 0);
      begin
        idle(5 * BIT + BIT / 2);
        rst = 1'b1;
        #1;
        check("midrst_data", rx_data, 8'h00);
        check("midrst_valid", rx_valid, 0);
        check("midrst_ferr", frame_err, 0);
        check("midrst_ovr", overrun, 0);
        @(negedge clk);
        rst = 1'b0;
      end
    join
    idle(10);
    check("midrst_abandoned", vrise_cnt - v0, 0);
    send_frame(8'h0F, 1'b1, 0);
    idle(10);
    check("midrst_next_data", rx_data, 8'h0F);
    check("midrst_next_valid", rx_valid, 1);
    consume();

    foreach (tbl[i]) begin
      f0 = ferr_cnt;
      send_frame(tbl[i].d, tbl[i].stop_ok, 600);
      idle(10);
      check($sformatf("tbl%0d_valid", i), rx_valid, tbl[i].exp_valid);
      check($sformatf("tbl%0d_data", i), rx_data, tbl[i].exp_data);
      check($sformatf("tbl%0d_ferr", i), ferr_cnt - f0, tbl[i].exp_ferr);
      if (tbl[i].exp_valid) consume();
    end

`ifdef UART_RX_PARITY_EN
    v0 = vrise_cnt;
    f0 = perr_cnt;
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1, 0);
    idle(10);
    check("par_bad_pulse", perr_cnt - f0, 1);
    check("par_bad_no_valid", vrise_cnt - v0, 0);
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1, 0);
    idle(10);
    check("par_ok_data", rx_data, 8'h07);
    check("par_ok_valid", rx_valid, 1);
    check("par_ok_no_err", perr_cnt - f0, 1);
    consume();
`endif

    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(5);
    m_valid = 1'b0;
    m_data = 8'h00;
    e_ferr = 0;
    e_ovr = 0;
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    for (int i = 0; i < 4; i++) begin
      rd = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      send_frame(rd, ok, 500);
      idle(10);
      if (!ok)
        e_ferr++;
      else if (m_valid)
        e_ovr++;
      else begin
        m_valid = 1'b1;
        m_data = rd;
      end
      check($sformatf("rnd%0d_valid", i), rx_valid, m_valid);
      check($sformatf("rnd%0d_data", i), rx_data, m_data);
      check($sformatf("rnd%0d_ferr", i), ferr_cnt - f0, e_ferr);
      check($sformatf("rnd%0d_ovr", i), ovr_cnt - o0, e_ovr);
      if ($urandom_range(0, 1) == 1 && m_valid) begin
        consume();
        m_valid = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
